// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_AEMPTY_LVL = 2;

    // Pointers and the occupancy counter carry one extra bit so that
    // "full" (DEPTH) is representable alongside "empty" (0).
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Number of storage entries for a given address width.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  flush_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output flush_i, wr_en_i, wr_data_i, rd_en_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, rd_en_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// The array is deliberately left without reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Store the accepted write word at the write index.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_r[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_r[rd_addr_i];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, almost-full/empty levels and
// sticky overflow/underflow flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// without it rd_data_o is registered and valid one cycle after the pop.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_LVL  = depth_of(ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic        clk_i,
    input  logic        aresetn_i,
    sync_fifo_if.slave  bus
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int CNT_W = cnt_width(ADDR_WIDTH);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [CNT_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  ovf_event_s;
    logic                  udf_event_s;
    logic [DATA_WIDTH-1:0] mem_rd_data_s;

    // Status flags and accept decisions, all derived from registered count.
    // Flush overrides any request in the same cycle.
    always_comb begin
        full_s      = 1'b0;
        empty_s     = 1'b0;
        rd_accept_s = 1'b0;
        wr_accept_s = 1'b0;
        ovf_event_s = 1'b0;
        udf_event_s = 1'b0;
        full_s      = (count_r == DEPTH_C);
        empty_s     = (count_r == ZERO_C);
        if (bus.flush_i) begin
            rd_accept_s = 1'b0;
            wr_accept_s = 1'b0;
        end else begin
            // A pop in the same cycle frees a slot, so a full FIFO still
            // takes the write.
            rd_accept_s = bus.rd_en_i && !empty_s;
            wr_accept_s = bus.wr_en_i && (!full_s || rd_accept_s);
            ovf_event_s = bus.wr_en_i && !wr_accept_s;
            udf_event_s = bus.rd_en_i && empty_s;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (wr_accept_s),
        .wr_addr_i (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wr_data_i (bus.wr_data_i),
        .rd_addr_i (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rd_data_o (mem_rd_data_s)
    );

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            count_r  <= ZERO_C;
        end else if (bus.flush_i) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            count_r  <= ZERO_C;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; only flush or reset clears them.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.flush_i) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | ovf_event_s;
            underflow_r <= underflow_r | udf_event_s;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; a pop advances to the next entry.
    assign bus.rd_data_o  = mem_rd_data_s;
    assign bus.rd_valid_o = !empty_s;
`else
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;

    // Capture the popped word; valid pulses for one cycle, data holds.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            rd_data_r  <= {DATA_WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (bus.flush_i) begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= 1'b0;
        end else if (rd_accept_s) begin
            rd_data_r  <= mem_rd_data_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_data_r  <= rd_data_r;
            rd_valid_r <= 1'b0;
        end
    end

    assign bus.rd_data_o  = rd_data_r;
    assign bus.rd_valid_o = rd_valid_r;
`endif

    assign bus.full_o         = full_s;
    assign bus.empty_o        = empty_s;
    assign bus.almost_full_o  = (count_r >= AFULL_C);
    assign bus.almost_empty_o = (count_r <= AEMPTY_C);
    assign bus.count_o        = count_r;
    assign bus.overflow_o     = overflow_r;
    assign bus.underflow_o    = underflow_r;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH=16, DATA_WIDTH=32).
// Works in both the standard and the SYNC_FIFO_FWFT_EN build.
module tb_sync_fifo;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    sync_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AFULL_LVL  (14),
        .AEMPTY_LVL (2)
    ) dut (
        .clk_i     (clk),
        .aresetn_i (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = d;
        step();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        chk({tag, "_vld"}, 32'(bus.rd_valid_o), 32'd1);
        chk(tag, bus.rd_data_o, exp);
        bus.rd_en_i = 1'b1;
        step();
        bus.rd_en_i = 1'b0;
`else
        bus.rd_en_i = 1'b1;
        step();
        bus.rd_en_i = 1'b0;
        chk({tag, "_vld"}, 32'(bus.rd_valid_o), 32'd1);
        chk(tag, bus.rd_data_o, exp);
`endif
    endtask

    task automatic flush();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
    endtask

    // Count plus every level flag for an expected occupancy c.
    task automatic chk_lvl(input string tag, input int c);
        chk({tag, "_cnt"},   32'(bus.count_o),        32'(c));
        chk({tag, "_full"},  32'(bus.full_o),         32'(c == 16));
        chk({tag, "_empty"}, 32'(bus.empty_o),        32'(c == 0));
        chk({tag, "_afull"}, 32'(bus.almost_full_o),  32'(c >= 14));
        chk({tag, "_aemp"},  32'(bus.almost_empty_o), 32'(c <= 2));
    endtask

    task automatic chk_err(input string tag, input int ovf, input int udf);
        chk({tag, "_ovf"}, 32'(bus.overflow_o),  32'(ovf));
        chk({tag, "_udf"}, 32'(bus.underflow_o), 32'(udf));
    endtask

    initial begin
        bus.flush_i   = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.rd_en_i   = 1'b0;
        bus.wr_data_i = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_lvl("rst", 0);
        chk_err("rst", 0, 0);
        chk("rst_vld", 32'(bus.rd_valid_o), 32'(bus.empty_o == 1'b0));
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_data", bus.rd_data_o, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // In-order fill and drain with a full level sweep
        chk_lvl("t26_c0", 0);
        for (int i = 0; i < 16; i++) begin
            push(32'(i));
            chk_lvl($sformatf("t26_w%0d", i), i + 1);
        end
        for (int i = 0; i < 16; i++) begin
            pop($sformatf("t26_d%0d", i), 32'(i));
            chk_lvl($sformatf("t26_r%0d", i), 15 - i);
        end
        chk_err("t26", 0, 0);
        step();
        chk("t26_idle_vld", 32'(bus.rd_valid_o), 32'd0);

        // Write into a full FIFO is dropped
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
        push(32'hDEAD);
        chk_err("t27_after", 1, 0);
        chk_lvl("t27_after", 16);
        for (int i = 0; i < 16; i++) pop($sformatf("t27_d%0d", i), 32'h100 + 32'(i));
        chk_lvl("t27_end", 0);
        chk_err("t27_sticky", 1, 0);
        flush();
        chk_err("t27_flush", 0, 0);

        // Simultaneous write/read on empty: write only
        bus.wr_en_i   = 1'b1;
        bus.rd_en_i   = 1'b1;
        bus.wr_data_i = 32'h55;
        step();
        bus.wr_en_i   = 1'b0;
        bus.rd_en_i   = 1'b0;
        chk_err("t28", 0, 1);
        chk_lvl("t28", 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t28_vld", 32'(bus.rd_valid_o), 32'd0);
`endif
        pop("t28_d", 32'h55);
        flush();

        // Full with streaming write+read across pointer wrap
        for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
        for (int k = 0; k < 40; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
            chk($sformatf("t29_d%0d", k), bus.rd_data_o, 32'h200 + 32'(k));
`endif
            bus.wr_en_i   = 1'b1;
            bus.rd_en_i   = 1'b1;
            bus.wr_data_i = 32'h210 + 32'(k);
            step();
`ifndef SYNC_FIFO_FWFT_EN
            chk($sformatf("t29_d%0d", k), bus.rd_data_o, 32'h200 + 32'(k));
            chk($sformatf("t29_v%0d", k), 32'(bus.rd_valid_o), 32'd1);
`endif
            chk($sformatf("t29_c%0d", k), 32'(bus.count_o), 32'd16);
        end
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        chk_err("t29", 0, 0);
        for (int i = 0; i < 16; i++) pop($sformatf("t29_tail%0d", i), 32'h228 + 32'(i));
        chk_lvl("t29_end", 0);

        // Flush beats a same-cycle write and clears the flags
        bus.rd_en_i = 1'b1;
        step();
        bus.rd_en_i = 1'b0;
        chk_err("t30_pre", 0, 1);
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
        chk_lvl("t30_fill", 5);
        bus.flush_i   = 1'b1;
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 32'h77;
        step();
        bus.flush_i   = 1'b0;
        bus.wr_en_i   = 1'b0;
        chk_lvl("t30_flush", 0);
        chk_err("t30_flush", 0, 0);
        chk("t30_vld", 32'(bus.rd_valid_o), 32'd0);
        push(32'h99);
        pop("t30_d", 32'h99);
        chk_lvl("t30_end", 0);

        // Reset mid-operation discards queued words
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(i));
        rst_n = 1'b0;
        #1;
        chk_lvl("t20_rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(32'hA1);
        pop("t20_d", 32'hA1);
        chk_lvl("t20_end", 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
